// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of the UART TX FIFO write port.
// A stall watchdog frees a grant whose owner stops sending mid-packet.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          timeout_pulse
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        stall_q, stall_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic                  arb_hit;
    logic [PW-1:0]         arb_idx;
    logic [PW-1:0]         next_ptr;
    logic                  xfer;
    logic                  expire;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!arb_hit && req_valid[PW'(idx)]) begin
                arb_hit = 1'b1;
                arb_idx = PW'(idx);
            end
        end
    end

    assign next_ptr = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
    assign expire   = (stall_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        stall_d  = stall_q;
        unique case (state_q)
            IDLE: begin
                if (ena && arb_hit) begin
                    state_d          = LOCKED;
                    owner_d          = arb_idx;
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    stall_d          = '0;
                end
            end
            LOCKED: begin
                if (ena) begin
                    if (xfer) begin
                        stall_d = '0;
                        if (req_last[owner_q]) begin
                            state_d  = IDLE;
                            grant_d  = '0;
                            rr_ptr_d = next_ptr;
                        end
                    end else if (expire) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        stall_d  = '0;
                    end else begin
                        stall_d = stall_q + CW'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        out_data      = '0;
        out_valid     = 1'b0;
        req_ready     = '0;
        timeout_pulse = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            LOCKED: begin
                out_data           = data_arr[owner_q];
                out_valid          = ena & req_valid[owner_q];
                req_ready[owner_q] = ena & out_ready;
                timeout_pulse      = ena & expire & ~(out_valid & out_ready);
            end
        endcase
    end

    assign xfer  = out_valid & out_ready;
    assign busy  = (state_q == LOCKED);
    assign grant = grant_q;

    a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_q));
    a_busy_grant : assert property (@(posedge clk) disable iff (reset)
        busy == (|grant_q));
    a_stall_bound : assert property (@(posedge clk) disable iff (reset)
        stall_q < CW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: cycle vectors for arbitration order plus hand-written
// watchdog, enable and reset sequences; a scoreboard checks the FIFO byte stream.
module tb_uart_tx_arbiter;

    localparam int DW = 8;
    localparam int NR = 2;
    localparam int TO = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           ena;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_last;
    logic [NR-1:0]  req_ready;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic [NR-1:0]  grant;
    logic           busy;
    logic           timeout_pulse;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] sb_exp;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] vld;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] lst;
        logic       rdy;
        logic [1:0] eg;
        logic       eb;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] er;
        logic       et;
    } vec_t;

    vec_t vt[64];
    int   nv = 0;

    uart_tx_arbiter #(
        .DATA_WIDTH    (DW),
        .NUM_REQ       (NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .grant        (grant),
        .busy         (busy),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic e, input logic [1:0] v,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] l, input logic o,
                                input logic [1:0] eg, input logic eb, input logic ev,
                                input logic [7:0] ed, input logic [1:0] er,
                                input logic et);
        vt[nv].rst = r;  vt[nv].en = e;  vt[nv].vld = v;
        vt[nv].d0  = a;  vt[nv].d1 = b;  vt[nv].lst = l;
        vt[nv].rdy = o;  vt[nv].eg = eg; vt[nv].eb  = eb;
        vt[nv].ev  = ev; vt[nv].ed = ed; vt[nv].er  = er;
        vt[nv].et  = et;
        nv++;
    endfunction

    task automatic drive(input logic r, input logic e, input logic [1:0] v,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] l, input logic o);
        @(posedge clk);
        #1;
        reset     = r;
        ena       = e;
        req_valid = v;
        req_data  = {b, a};
        req_last  = l;
        out_ready = o;
    endtask

    task automatic chk(input string nm, input logic [1:0] eg, input logic eb,
                       input logic ev, input logic [7:0] ed,
                       input logic [1:0] er, input logic et);
        logic ok;
        #3;
        n_vec++;
        ok = (grant === eg) && (busy === eb) && (out_valid === ev) &&
             (req_ready === er) && (timeout_pulse === et) &&
             (!ev || out_data === ed);
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got grant=%b busy=%b ov=%b data=%h rdy=%b tp=%b, want grant=%b busy=%b ov=%b data=%h rdy=%b tp=%b",
                     nm, grant, busy, out_valid, out_data, req_ready, timeout_pulse,
                     eg, eb, ev, ed, er, et);
        end
        if (ev && out_ready && ena && !reset) begin
            sb.push_back(ed);
        end
    endtask

    // Every byte the FIFO accepts must be the next one the stimulus expected.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got byte %h, want no byte", out_data);
            end else begin
                sb_exp = sb.pop_front();
                if (out_data !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_order: got byte %h, want %h", out_data, sb_exp);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        ena       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b0;

        // single 3-byte packet from req0
        add(0,1,2'b01,8'h41,8'h00,2'b00,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b01,8'h41,8'h00,2'b00,1, 2'b01,1,1,8'h41,2'b01,0);
        add(0,1,2'b01,8'h42,8'h00,2'b00,1, 2'b01,1,1,8'h42,2'b01,0);
        add(0,1,2'b01,8'h43,8'h00,2'b01,1, 2'b01,1,1,8'h43,2'b01,0);
        add(1,1,2'b00,8'h00,8'h00,2'b00,1, 2'b00,0,0,8'h00,2'b00,0);
        // both requesting, pointer at 0
        add(0,1,2'b11,8'hA0,8'hB0,2'b00,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b11,8'hA0,8'hB0,2'b00,1, 2'b01,1,1,8'hA0,2'b01,0);
        add(0,1,2'b11,8'hA1,8'hB0,2'b01,1, 2'b01,1,1,8'hA1,2'b01,0);
        add(0,1,2'b10,8'h00,8'hB0,2'b00,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b10,8'h00,8'hB0,2'b00,1, 2'b10,1,1,8'hB0,2'b10,0);
        add(0,1,2'b10,8'h00,8'hB1,2'b10,1, 2'b10,1,1,8'hB1,2'b10,0);
        add(0,1,2'b11,8'hC0,8'hD0,2'b00,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b11,8'hC0,8'hD0,2'b01,1, 2'b01,1,1,8'hC0,2'b01,0);
        add(0,1,2'b10,8'h00,8'hD0,2'b10,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b10,8'h00,8'hD0,2'b10,1, 2'b10,1,1,8'hD0,2'b10,0);
        add(0,1,2'b00,8'h00,8'h00,2'b00,1, 2'b00,0,0,8'h00,2'b00,0);
        // req0 back-to-back while req1 waits
        add(0,1,2'b01,8'hE0,8'h00,2'b01,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b11,8'hE0,8'hF0,2'b11,1, 2'b01,1,1,8'hE0,2'b01,0);
        add(0,1,2'b11,8'hE1,8'hF0,2'b11,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b11,8'hE1,8'hF0,2'b11,1, 2'b10,1,1,8'hF0,2'b10,0);
        add(0,1,2'b01,8'hE1,8'h00,2'b01,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b01,8'hE1,8'h00,2'b01,1, 2'b01,1,1,8'hE1,2'b01,0);
        add(0,1,2'b00,8'h00,8'h00,2'b00,1, 2'b00,0,0,8'h00,2'b00,0);
        // req1 stalled by out_ready low for 5 cycles, req0 waiting
        add(0,1,2'b11,8'h30,8'h50,2'b00,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b11,8'h30,8'h50,2'b00,1, 2'b10,1,1,8'h50,2'b10,0);
        for (int i = 0; i < 5; i++) begin
            add(0,1,2'b11,8'h30,8'h51,2'b00,0, 2'b10,1,1,8'h51,2'b00,0);
        end
        add(0,1,2'b11,8'h30,8'h51,2'b10,1, 2'b10,1,1,8'h51,2'b10,0);
        add(0,1,2'b01,8'h30,8'h00,2'b01,1, 2'b00,0,0,8'h00,2'b00,0);
        add(0,1,2'b01,8'h30,8'h00,2'b01,1, 2'b01,1,1,8'h30,2'b01,0);

        drive(1,0,2'b00,8'h00,8'h00,2'b00,0);
        drive(1,0,2'b00,8'h00,8'h00,2'b00,0);
        chk("reset_state", 2'b00,0,0,8'h00,2'b00,0);

        for (int i = 0; i < nv; i++) begin
            drive(vt[i].rst, vt[i].en, vt[i].vld, vt[i].d0, vt[i].d1,
                  vt[i].lst, vt[i].rdy);
            chk($sformatf("vec%0d", i), vt[i].eg, vt[i].eb, vt[i].ev,
                vt[i].ed, vt[i].er, vt[i].et);
        end

        // watchdog: req1 goes quiet after one byte, req0 waiting
        drive(0,1,2'b11,8'h60,8'h70,2'b00,1);
        chk("to_idle", 2'b00,0,0,8'h00,2'b00,0);
        drive(0,1,2'b11,8'h60,8'h70,2'b00,1);
        chk("to_byte0", 2'b10,1,1,8'h70,2'b10,0);
        for (int i = 1; i < TO; i++) begin
            drive(0,1,2'b01,8'h60,8'h71,2'b00,1);
            chk($sformatf("to_stall%0d", i), 2'b10,1,0,8'h00,2'b10,0);
        end
        drive(0,1,2'b01,8'h60,8'h71,2'b00,1);
        chk("to_pulse", 2'b10,1,0,8'h00,2'b10,1);
        drive(0,1,2'b01,8'h60,8'h00,2'b01,1);
        chk("to_released", 2'b00,0,0,8'h00,2'b00,0);
        drive(0,1,2'b01,8'h60,8'h00,2'b01,1);
        chk("to_req0_next", 2'b01,1,1,8'h60,2'b01,0);

        // transfer in the expiry cycle beats the watchdog
        drive(0,1,2'b10,8'h00,8'h80,2'b00,1);
        chk("exp_idle", 2'b00,0,0,8'h00,2'b00,0);
        drive(0,1,2'b10,8'h00,8'h80,2'b00,1);
        chk("exp_byte0", 2'b10,1,1,8'h80,2'b10,0);
        for (int i = 1; i < TO; i++) begin
            drive(0,1,2'b00,8'h00,8'h81,2'b00,1);
            chk($sformatf("exp_stall%0d", i), 2'b10,1,0,8'h00,2'b10,0);
        end
        drive(0,1,2'b10,8'h00,8'h81,2'b00,1);
        chk("exp_xfer_wins", 2'b10,1,1,8'h81,2'b10,0);
        drive(0,1,2'b10,8'h00,8'h82,2'b10,1);
        chk("exp_still_locked", 2'b10,1,1,8'h82,2'b10,0);

        // enable low: no grant in idle, counter frozen while locked
        drive(0,0,2'b01,8'h90,8'h00,2'b00,1);
        chk("ena_idle_off", 2'b00,0,0,8'h00,2'b00,0);
        drive(0,1,2'b01,8'h90,8'h00,2'b00,1);
        chk("ena_idle_on", 2'b00,0,0,8'h00,2'b00,0);
        drive(0,1,2'b01,8'h90,8'h00,2'b00,1);
        chk("ena_byte0", 2'b01,1,1,8'h90,2'b01,0);
        for (int i = 0; i < 2; i++) begin
            drive(0,1,2'b00,8'h91,8'h00,2'b00,1);
            chk($sformatf("ena_pre%0d", i), 2'b01,1,0,8'h00,2'b01,0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0,0,2'b01,8'h91,8'h00,2'b00,1);
            chk($sformatf("ena_low%0d", i), 2'b01,1,0,8'h00,2'b00,0);
        end
        for (int i = 0; i < TO - 3; i++) begin
            drive(0,1,2'b00,8'h91,8'h00,2'b00,1);
            chk($sformatf("ena_post%0d", i), 2'b01,1,0,8'h00,2'b01,0);
        end
        drive(0,1,2'b01,8'h91,8'h00,2'b00,1);
        chk("ena_resume", 2'b01,1,1,8'h91,2'b01,0);
        drive(0,1,2'b01,8'h92,8'h00,2'b01,1);
        chk("ena_last", 2'b01,1,1,8'h92,2'b01,0);

        // reset during byte 2 of a 4-byte packet from req1
        drive(0,1,2'b10,8'h00,8'hB0,2'b00,1);
        chk("rst_idle", 2'b00,0,0,8'h00,2'b00,0);
        drive(0,1,2'b10,8'h00,8'hB0,2'b00,1);
        chk("rst_byte0", 2'b10,1,1,8'hB0,2'b10,0);
        drive(1,1,2'b10,8'h00,8'hB1,2'b00,1);
        drive(0,1,2'b11,8'hC0,8'hB2,2'b00,1);
        chk("rst_after", 2'b00,0,0,8'h00,2'b00,0);
        drive(0,1,2'b11,8'hC0,8'hB2,2'b01,1);
        chk("rst_ptr_zero", 2'b01,1,1,8'hC0,2'b01,0);
        drive(0,1,2'b00,8'h00,8'h00,2'b00,1);
        chk("final_idle", 2'b00,0,0,8'h00,2'b00,0);

        #3;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d bytes still expected, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
